// File: rtl/uart_rcv_if.sv
// Ingress-side signal bundle for the UART receiver: serial line in, FIFO write
// port out, plus status pulses. The receiver is the master of the write port.
interface uart_rcv_if;
  logic       txd_in;
  logic       ig_full;
  logic       ig_wr_en;
  logic [7:0] ig_wr_data;
  logic       active;
  logic       done;
  logic       frame_err;
  logic       ovf_err;

  modport master (
    input  txd_in,
    input  ig_full,
    output ig_wr_en,
    output ig_wr_data,
    output active,
    output done,
    output frame_err,
    output ovf_err
  );

  modport slave (
    output txd_in,
    output ig_full,
    input  ig_wr_en,
    input  ig_wr_data,
    input  active,
    input  done,
    input  frame_err,
    input  ovf_err
  );
endinterface

// File: rtl/uart_rcv.sv
// UART 8N1 receive front end. Synchronises the serial line, samples each bit at
// its mid-point and writes good bytes into the ingress FIFO.
module uart_rcv #(
  parameter int unsigned WAIT_TIME = 868
) (
  input  logic       clk,
  input  logic       rst,
  uart_rcv_if.master bus
);

  localparam int unsigned CntW = $clog2(WAIT_TIME);
  localparam logic [CntW-1:0] CntHalf = CntW'(WAIT_TIME / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(WAIT_TIME - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            active_q, active_d;
  logic            wr_q, wr_d;
  logic            ferr_q, ferr_d;
  logic            ovf_q, ovf_d;
  logic            sync_q, rx_s_q;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      sync_q <= bus.txd_in;
      rx_s_q <= sync_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      active_q <= 1'b0;
      wr_q     <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      active_q <= active_d;
      wr_q     <= wr_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Frame recovery: next state, sampling and one-cycle pulse generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    active_d = active_q;
    wr_d     = 1'b0;
    ferr_d   = 1'b0;
    ovf_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d    = '0;
        active_d = 1'b0;
        if (!rx_s_q) begin
          state_d  = StStart;
          active_d = 1'b1;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            idx_d   = '0;
            state_d = StData;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            active_d = 1'b0;
            state_d  = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CntFull) begin
          cnt_d    = '0;
          active_d = 1'b0;
          if (rx_s_q) begin
            if (!bus.ig_full) begin
              wr_d   = 1'b1;
              data_d = shift_q;
            end else begin
              ovf_d = 1'b1;
            end
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitHigh: begin
        // Swallow a held-low break so it is not re-read as 0x00 frames.
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.ig_wr_en   = wr_q;
  assign bus.done       = wr_q;
  assign bus.ig_wr_data = data_q;
  assign bus.active     = active_q;
  assign bus.frame_err  = ferr_q;
  assign bus.ovf_err    = ovf_q;

endmodule
